score_display_ctrl: RTL and testbench

Sequential controller that owns the game's hex displays. It accepts a binary score over a valid/ready handshake and converts it to BCD with a multi-cycle shift-add-3 (double-dabble) sequence. It then latches the digits, applies optional leading-zero blanking and overflow saturation, and drives one `seven_seg_decoder` instance per digit. It sits between the game-state logic (score counter) and the HEX pins.

---
 rtl/display_pkg.sv | 23 ++
 rtl/seven_seg_decoder.sv | 26 ++
 rtl/score_display_ctrl.sv | 140 ++++++++++++++
 tb/tb_score_display_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the score display controller.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } disp_state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low seven-segment pattern (gfedcba).
module seven_seg_decoder
    import display_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (digit)
            4'd0: seg_n = 7'b1000000;
            4'd1: seg_n = 7'b1111001;
            4'd2: seg_n = 7'b0100100;
            4'd3: seg_n = 7'b0110000;
            4'd4: seg_n = 7'b0011001;
            4'd5: seg_n = 7'b0010010;
            4'd6: seg_n = 7'b0000010;
            4'd7: seg_n = 7'b1111000;
            4'd8: seg_n = 7'b0000000;
            4'd9: seg_n = 7'b0010000;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Binary score to BCD (double-dabble) with latched, blanked,
// saturating seven-segment outputs.
module score_display_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BIN_W-1:0]      score,
    input  logic                  score_valid,
    output logic                  score_ready,
    input  logic                  blank_lz,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    disp_state_t        state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               blz_q, blz_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [DIGITS-1:0]  blank_q, blank_d;

    logic [31:0]        score_ext;
    logic               score_big;
    logic [BCD_W-1:0]   bcd_adj;
    logic [DIGITS-1:0]  mask_new;

    assign score_ext = 32'(score);
    assign score_big = score_ext > LIMIT;

    // Per-nibble add-3; saturated input keeps every nibble <= 9.
    always_comb begin
        bcd_t nib;
        bcd_adj = '0;
        nib     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd_q[4*i +: 4];
            bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    always_comb begin
        logic run_zero;
        mask_new = '0;
        run_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run_zero    = run_zero && (bcd_q[4*i +: 4] == 4'd0);
            mask_new[i] = blz_q && run_zero;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        blz_d      = blz_q;
        pend_ovf_d = pend_ovf_q;
        ovf_d      = ovf_q;
        digits_d   = digits_q;
        blank_d    = blank_q;
        unique case (state_q)
            IDLE: begin
                if (score_valid) begin
                    shreg_d    = score_big ? BIN_W'(LIMIT) : score;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    blz_d      = blank_lz;
                    pend_ovf_d = score_big;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d   = {bcd_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
                shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                digits_d = bcd_q;
                blank_d  = mask_new;
                ovf_d    = pend_ovf_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            blz_q      <= 1'b0;
            pend_ovf_q <= 1'b0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            blank_q    <= BLANK_RST;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            blz_q      <= blz_d;
            pend_ovf_q <= pend_ovf_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
        end
    end

    assign score_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign overflow    = ovf_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [6:0] seg_n;
        seven_seg_decoder u_dec (
            .digit (digits_q[4*g +: 4]),
            .seg_n (seg_n)
        );
        assign hex_out[7*g +: 7] = blank_q[g] ? SEG_BLANK : seg_n;
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl (DIGITS=4, BIN_W=14).
module tb_score_display_ctrl;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S6  = 7'b0000010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] S9  = 7'b0010000;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [27:0] RST_HEX = {BLK, BLK, BLK, S0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] score = '0;
    logic        score_valid = 1'b0;
    logic        score_ready;
    logic        blank_lz = 1'b0;
    logic [27:0] hex_out;
    logic        busy;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    score_display_ctrl #(.DIGITS(4), .BIN_W(14)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .score       (score),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .blank_lz    (blank_lz),
        .hex_out     (hex_out),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Four digits, no blanking, value below 10000.
    function automatic logic [27:0] hex4(input int v);
        return {seg_tab[(v / 1000) % 10], seg_tab[(v / 100) % 10],
                seg_tab[(v / 10) % 10], seg_tab[v % 10]};
    endfunction

    task automatic send(input logic [13:0] s, input logic b);
        @(negedge clk);
        check("ready_pre", 32'(score_ready), 32'd1);
        score       = s;
        blank_lz    = b;
        score_valid = 1'b1;
        @(posedge clk);
        #1 score_valid = 1'b0;
    endtask

    // Ends at the negedge after the LATCH edge.
    task automatic convert(input logic [13:0] s, input logic b);
        int cnt;
        send(s, b);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        check("busy_len", 32'(cnt), 32'd15);
    endtask

    initial begin
        int last_a;
        int n_acc;
        int acc_val;
        logic have_acc;
        logic [27:0] disp_exp;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_hex", 32'(hex_out), 32'(RST_HEX));
        check("rst_ready", 32'(score_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // 1234, display must stay at reset pattern mid-conversion
        send(14'd1234, 1'b0);
        repeat (6) @(negedge clk);
        check("mid_hold", 32'(hex_out), 32'(RST_HEX));
        repeat (12) @(negedge clk);
        check("h1234", 32'(hex_out), 32'({S1, S2, S3, S4}));
        check("ovf1234", 32'(overflow), 32'd0);
        convert(14'd1234, 1'b0);
        check("h1234b", 32'(hex_out), 32'({S1, S2, S3, S4}));
        check("rdy_after", 32'(score_ready), 32'd1);

        convert(14'd7, 1'b1);
        check("h7_lz", 32'(hex_out), 32'({BLK, BLK, BLK, S7}));
        convert(14'd0, 1'b1);
        check("h0_lz", 32'(hex_out), 32'({BLK, BLK, BLK, S0}));
        convert(14'd305, 1'b1);
        check("h305_lz", 32'(hex_out), 32'({BLK, S3, S0, 7'b0010010}));

        convert(14'd12000, 1'b0);
        check("h_sat", 32'(hex_out), 32'({S9, S9, S9, S9}));
        check("ovf_set", 32'(overflow), 32'd1);
        send(14'd42, 1'b0);
        repeat (8) @(negedge clk);
        check("ovf_hold", 32'(overflow), 32'd1);
        repeat (8) @(negedge clk);
        check("h42", 32'(hex_out), 32'({S0, S0, S4, S2}));
        check("ovf_clr", 32'(overflow), 32'd0);

        convert(14'd9999, 1'b0);
        check("h9999", 32'(hex_out), 32'({S9, S9, S9, S9}));
        check("ovf9999", 32'(overflow), 32'd0);
        convert(14'd10000, 1'b0);
        check("ovf10000", 32'(overflow), 32'd1);
        convert(14'd16383, 1'b1);
        check("h_max", 32'(hex_out), 32'({S9, S9, S9, S9}));

        // Back-to-back with valid held and score moving every cycle
        convert(14'd42, 1'b0);
        disp_exp = {S0, S0, S4, S2};
        have_acc = 1'b0;
        last_a   = 0;
        n_acc    = 0;
        acc_val  = 0;
        for (int i = 0; i < 50; i++) begin
            if (i > 0) @(negedge clk);
            score       = 14'(1000 + i * 7);
            blank_lz    = 1'b0;
            score_valid = 1'b1;
            if (have_acc && i == last_a + 16) disp_exp = hex4(acc_val);
            check("strm_hex", 32'(hex_out), 32'(disp_exp));
            if (score_ready) begin
                if (have_acc) check("acc_gap", 32'(i - last_a), 32'd16);
                have_acc = 1'b1;
                last_a   = i;
                acc_val  = 1000 + i * 7;
                n_acc++;
            end
        end
        @(posedge clk);
        #1 score_valid = 1'b0;
        check("acc_cnt", 32'(n_acc), 32'd4);
        repeat (16) @(negedge clk);
        check("strm_last", 32'(hex_out), 32'(hex4(acc_val)));

        // Reset in the middle of converting 5555
        send(14'd5555, 1'b0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mrst_hex", 32'(hex_out), 32'(RST_HEX));
        check("mrst_rdy", 32'(score_ready), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("mrst_nolatch", 32'(hex_out), 32'(RST_HEX));
        convert(14'd8642, 1'b0);
        check("h8642", 32'(hex_out), 32'({S8, S6, S4, S2}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
